// File: rtl/cic_comp_fir.sv
// -----------------------------------------------------------------------------
// cic_comp_fir
//   CIC droop compensator running at the decimated rate. Applies the fixed
//   symmetric 3-tap FIR h = [-A, 2^SHIFT+2A, -A] / 2^SHIFT (unity DC gain),
//   rounds half-up, and saturates the result back to WIDTH bits.
//
// Ports
//   clk        clock
//   rstn       asynchronous active-low reset
//   in_data    signed input sample (WIDTH)
//   in_valid   in_data is valid this cycle
//   in_ready   block accepts in_data this cycle
//   out_data   compensated signed sample (WIDTH)
//   out_valid  out_data is valid; held until accepted
//   out_ready  consumer accepts out_data this cycle
//   sat        sticky flag: some output was clamped
//   sat_clr    synchronous clear of sat (a new clamp event wins)
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer never drops valid or changes data until the transfer
// happens. Here in_ready = !(out_valid && !out_ready), i.e. the whole pipe
// (delay line, stage 1, stage 2) freezes while the output is stalled, so a
// pending stage-1 result is never lost.
//
// Pipeline
//   stage 1: three tap products, registered, with the delay line shift.
//   stage 2: sum + rounding constant, arithmetic shift, clamp, output register.
// -----------------------------------------------------------------------------
module cic_comp_fir #(
  parameter int WIDTH      = 16,
  parameter int A          = 2,
  parameter int SHIFT      = 4,
  parameter bit SVA_ENABLE = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sat,
  input  logic             sat_clr
);

  // Wide enough for the full tap sum: the centre coefficient is at most
  // 2^(SHIFT+1), the outer ones 2^(SHIFT-1), plus sign and rounding headroom.
  localparam int ACC_W = WIDTH + SHIFT + 3;

  typedef logic signed [ACC_W-1:0] acc_t;

  localparam acc_t C_OUT = acc_t'(A);
  localparam acc_t C_MID = acc_t'((1 << SHIFT) + 2 * A);
  localparam acc_t RND   = acc_t'(1 << (SHIFT - 1));
  localparam acc_t Y_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam acc_t Y_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  function automatic acc_t sext(input logic [WIDTH-1:0] v);
    return {{(ACC_W-WIDTH){v[WIDTH-1]}}, v};
  endfunction

  // Delay line: x1 is the previous accepted sample, x2 the one before.
  logic [WIDTH-1:0] x1;
  logic [WIDTH-1:0] x2;

  // Stage-1 registers
  acc_t p0;
  acc_t p1;
  acc_t p2;
  logic v1;

  // Handshake
  logic stall;
  logic accept;

  // Stage-2 combinational path
  acc_t             acc;
  acc_t             y;
  logic             clamp_hi;
  logic             clamp_lo;
  logic [WIDTH-1:0] y_sat;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;

  always_comb begin
    acc      = p0 + p1 + p2 + RND;
    y        = acc >>> SHIFT;
    clamp_hi = (y > Y_MAX);
    clamp_lo = (y < Y_MIN);
    y_sat    = y[WIDTH-1:0];
    if (clamp_hi) begin
      y_sat = Y_MAX[WIDTH-1:0];
    end else if (clamp_lo) begin
      y_sat = Y_MIN[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x1        <= '0;
      x2        <= '0;
      p0        <= '0;
      p1        <= '0;
      p2        <= '0;
      v1        <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (!stall) begin
      // Stage 1: products use the history before this sample shifts in.
      v1 <= accept;
      if (accept) begin
        p0 <= -(C_OUT * sext(in_data));
        p1 <= C_MID * sext(x1);
        p2 <= -(C_OUT * sext(x2));
        x2 <= x1;
        x1 <= in_data;
      end
      // Stage 2: not stalled means the output register is free or being
      // drained this cycle, so it either takes the new result or empties.
      out_valid <= v1;
      if (v1) begin
        out_data <= y_sat;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sat <= 1'b0;
    end else if (v1 && !stall && (clamp_hi || clamp_lo)) begin
      sat <= 1'b1;
    end else if (sat_clr) begin
      sat <= 1'b0;
    end
  end

  generate
    if (SVA_ENABLE) begin : g_sva
      a_out_stable : assert property (@(posedge clk) disable iff (!rstn)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));

      a_valid_no_drop : assert property (@(posedge clk) disable iff (!rstn)
        $fell(out_valid) |-> $past(out_ready));

      a_in_ready : assert property (@(posedge clk) disable iff (!rstn)
        in_ready == !(out_valid && !out_ready));
    end
  endgenerate

endmodule

// File: tb/tb_cic_comp_fir.sv
// -----------------------------------------------------------------------------
// tb_cic_comp_fir
//   Directed bench for cic_comp_fir (WIDTH=16, A=2, SHIFT=4).
//   Inputs change 1 ns after a rising edge; outputs are sampled on the falling
//   edge. A monitor pushes the model's expected output when a sample is
//   accepted and pops/compares it when an output transfer happens.
// -----------------------------------------------------------------------------
module tb_cic_comp_fir;

  localparam int W     = 16;
  localparam int A     = 2;
  localparam int SHIFT = 4;

  // ---------------------------------------------------------------- clock/reset
  logic         clk = 1'b0;
  logic         rstn;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         sat;
  logic         sat_clr;

  always #5 clk = ~clk;

  cic_comp_fir #(.WIDTH(W), .A(A), .SHIFT(SHIFT)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sat       (sat),
    .sat_clr   (sat_clr)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- scoreboard
  int           checks = 0;
  int           errors = 0;
  int           pops   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  logic [W-1:0] h1 = '0;
  logic [W-1:0] h2 = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer FIR, round half up, floor shift, clamp.
  function automatic logic [W-1:0] model(input logic [W-1:0] xin,
                                         input logic [W-1:0] xd1,
                                         input logic [W-1:0] xd2);
    longint s0, s1, s2, acc, y;
    s0  = longint'($signed(xin));
    s1  = longint'($signed(xd1));
    s2  = longint'($signed(xd2));
    acc = -A * s0 + ((2 ** SHIFT) + 2 * A) * s1 - A * s2 + (2 ** (SHIFT - 1));
    y   = acc >>> SHIFT;
    if (y > 32767)  y = 32767;
    if (y < -32768) y = -32768;
    return y[W-1:0];
  endfunction

  always @(negedge clk) begin
    if (rstn) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_data, h1, h2));
        h2 = h1;
        h1 = in_data;
      end
      if (out_valid && out_ready) begin
        pops++;
        got_q.push_back(out_data);
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'(out_data), 32'hDEAD_BEEF);
        end else begin
          check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic send(input logic [W-1:0] v);
    int n = 0;
    in_data  = v;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 60) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------- stimulus
  logic [W-1:0] held;

  initial begin
    rstn      = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sat_clr   = 1'b0;

    // Reset state
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_sat",       32'(sat),       32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    idle(3);
    rstn = 1'b1;
    idle(2);

    // 1: impulse
    got_q.delete();
    send(16'd100);
    for (int i = 0; i < 4; i++) send(16'd0);
    drain();
    check("imp0", 32'(got_q[0]), 32'h0000_FFF4);
    check("imp1", 32'(got_q[1]), 32'h0000_007D);
    check("imp2", 32'(got_q[2]), 32'h0000_FFF4);
    check("imp3", 32'(got_q[3]), 32'h0000_0000);

    // 2: DC
    got_q.delete();
    for (int i = 0; i < 6; i++) send(16'd1000);
    drain();
    check("dc0", 32'(got_q[0]), 32'h0000_FF83);
    check("dc1", 32'(got_q[1]), 32'h0000_0465);
    check("dc2", 32'(got_q[2]), 32'h0000_03E8);
    check("dc5", 32'(got_q[5]), 32'h0000_03E8);
    check("dc_sat", 32'(sat), 32'd0);

    // 3: saturation, then sticky flag and clear
    got_q.delete();
    for (int i = 0; i < 6; i++) send((i % 2 == 0) ? 16'h7FFF : 16'h8000);
    drain();
    check("sat_lo", 32'(got_q[2]), 32'h0000_8000);
    check("sat_hi", 32'(got_q[3]), 32'h0000_7FFF);
    idle(3);
    check("sat_sticky", 32'(sat), 32'd1);
    sat_clr = 1'b1;
    @(negedge clk);
    check("sat_before_clr_edge", 32'(sat), 32'd1);
    @(posedge clk);
    #1;
    sat_clr = 1'b0;
    check("sat_cleared", 32'(sat), 32'd0);

    // 4: backpressure with continuous input
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(16'($urandom_range(0, 65535)));
      end
      begin
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
          @(negedge clk);
          n++;
        end
        check("bp_valid_seen", 32'(out_valid), 32'd1);
        held = out_data;
        repeat (5) begin
          @(negedge clk);
          check("bp_in_ready", 32'(in_ready),  32'd0);
          check("bp_valid",    32'(out_valid), 32'd1);
          check("bp_stable",   32'(out_data),  32'(held));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // 5: back-to-back with out_ready=1: one transfer every cycle
    fork
      begin
        for (int i = 0; i < 8; i++) send(16'(1000 * i + 37));
      end
      begin
        int n = 0;
        int prev;
        @(negedge clk);
        while (!out_valid && n < 20) begin
          @(negedge clk);
          n++;
        end
        #1;
        prev = pops;
        repeat (6) begin
          @(negedge clk);
          #1;
          check("b2b_valid", 32'(out_valid), 32'd1);
          check("b2b_pop",   32'(pops - prev), 32'd1);
          prev = pops;
        end
      end
    join
    drain();

    // 6: reset mid-stream with v1=1 and out_valid=1
    send(16'd5000);
    send(16'd7000);
    #1;
    check("rst_pre_valid", 32'(out_valid), 32'd1);
    rstn = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_data",  32'(out_data),  32'd0);
    check("arst_in_ready",  32'(in_ready),  32'd1);
    check("arst_sat",       32'(sat),       32'd0);
    exp_q.delete();
    h1 = '0;
    h2 = '0;
    idle(2);
    rstn = 1'b1;
    idle(1);
    got_q.delete();
    send(16'd100);
    for (int i = 0; i < 3; i++) send(16'd0);
    drain();
    check("post_rst0", 32'(got_q[0]), 32'h0000_FFF4);
    check("post_rst1", 32'(got_q[1]), 32'h0000_007D);
    check("post_rst2", 32'(got_q[2]), 32'h0000_FFF4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
